// File: rtl/btb_update_queue.sv
// btb_update_queue: filters retiring control-flow instructions into an in-order FIFO that drains one BTB update per cycle
package btb_update_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_branch_address;
    logic        branch_inst;
    logic        jal_inst;
    logic        branch_resol;
    logic        ready;
    logic        valid;
  } rob_to_btb_bus;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        branch_inst;
    logic        jal_inst;
    logic        branch_resol;
  } btb_entry;
endpackage

module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int PTR_BITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c0_valid,
  input  logic [31:0]   c0_pc,
  input  logic [31:0]   c0_target,
  input  logic          c0_is_branch,
  input  logic          c0_is_jal,
  input  logic          c0_taken,
  input  logic          c0_pred_taken,
  input  logic          c1_valid,
  input  logic [31:0]   c1_pc,
  input  logic [31:0]   c1_target,
  input  logic          c1_is_branch,
  input  logic          c1_is_jal,
  input  logic          c1_taken,
  input  logic          c1_pred_taken,
  input  logic          drain_en,
  output rob_to_btb_bus btb_upd,
  output logic          commit_stall,
  output logic [31:0]   mispred_cnt,
  output logic          overflow_err
);
  localparam int CNT = PTR_BITS + 1;
  localparam int CW  = PTR_BITS + 2;

  btb_entry            mem [DEPTH];
  btb_entry            e0, e1;
  logic [PTR_BITS-1:0] head, tail;
  logic [CNT-1:0]      count;
  logic                q0, q1, m0, m1, deq, ovf;
  logic [1:0]          enq_n, acc;
  logic [CW-1:0]       space;
  logic [32:0]         cnt_sum;

  always_comb begin
    q0 = c0_valid && (c0_is_branch || c0_is_jal);
    q1 = c1_valid && (c1_is_branch || c1_is_jal);
    e0 = '{pc: c0_pc, target: c0_target, branch_inst: c0_is_branch && !c0_is_jal,
           jal_inst: c0_is_jal, branch_resol: c0_is_jal || c0_taken};
    e1 = '{pc: c1_pc, target: c1_target, branch_inst: c1_is_branch && !c1_is_jal,
           jal_inst: c1_is_jal, branch_resol: c1_is_jal || c1_taken};
    m0 = q0 && (e0.branch_resol != c0_pred_taken);
    m1 = q1 && (e1.branch_resol != c1_pred_taken);
    enq_n = {1'b0, q0} + {1'b0, q1};
    deq = (count != '0) && drain_en;
    // free slots this cycle, counting the entry that leaves on the same edge
    space = CW'(DEPTH) - CW'(count) + CW'(deq);
    acc = (CW'(enq_n) > space) ? space[1:0] : enq_n;
    ovf = acc != enq_n;
    cnt_sum = {1'b0, mispred_cnt} + 33'(m0) + 33'(m1);
  end

  // when only one entry fits, the older qualifying slot wins
  always_ff @(posedge clk) begin
    if (acc != 2'd0) mem[tail] <= q0 ? e0 : e1;
    if (acc == 2'd2) mem[tail + PTR_BITS'(1)] <= e1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      mispred_cnt  <= '0;
      overflow_err <= 1'b0;
    end else begin
      head         <= head + PTR_BITS'(deq);
      tail         <= tail + PTR_BITS'(acc);
      count        <= count + CNT'(acc) - CNT'(deq);
      mispred_cnt  <= cnt_sum[32] ? '1 : cnt_sum[31:0];
      overflow_err <= overflow_err | ovf;
    end
  end

  always_comb begin
    btb_upd.pc                  = mem[head].pc;
    btb_upd.pred_branch_address = mem[head].target;
    btb_upd.branch_inst         = mem[head].branch_inst;
    btb_upd.jal_inst            = mem[head].jal_inst;
    btb_upd.branch_resol        = mem[head].branch_resol;
    btb_upd.valid               = deq;
    btb_upd.ready               = deq;
  end

  assign commit_stall = count > CNT'(DEPTH - 2);
endmodule

// File: tb/tb_btb_update_queue.sv
// tb_btb_update_queue: table vectors plus a queue scoreboard and reference model for btb_update_queue
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          c0_valid, c0_is_branch, c0_is_jal, c0_taken, c0_pred_taken;
  logic          c1_valid, c1_is_branch, c1_is_jal, c1_taken, c1_pred_taken;
  logic [31:0]   c0_pc, c0_target, c1_pc, c1_target;
  logic          drain_en;
  rob_to_btb_bus btb_upd;
  logic          commit_stall;
  logic [31:0]   mispred_cnt;
  logic          overflow_err;

  btb_update_queue #(.DEPTH(DEPTH), .PTR_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_target(c0_target), .c0_is_branch(c0_is_branch),
    .c0_is_jal(c0_is_jal), .c0_taken(c0_taken), .c0_pred_taken(c0_pred_taken),
    .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_target(c1_target), .c1_is_branch(c1_is_branch),
    .c1_is_jal(c1_is_jal), .c1_taken(c1_taken), .c1_pred_taken(c1_pred_taken),
    .drain_en(drain_en), .btb_upd(btb_upd), .commit_stall(commit_stall),
    .mispred_cnt(mispred_cnt), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tg;
    logic        br;
    logic        jal;
    logic        resol;
  } exp_t;

  // flag fields are {valid, is_branch, is_jal, taken, pred_taken}
  typedef struct {
    logic [4:0]  f0;
    logic [31:0] pc0;
    logic [31:0] tg0;
    logic [4:0]  f1;
    logic [31:0] pc1;
    logic [31:0] tg1;
    logic        drain;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] emis;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] mcnt;
  logic        movf;
  int          n_cmp = 0;
  int          n_fail = 0;
  vec_t        vt[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] f0, input logic [31:0] pc0, input logic [31:0] tg0,
                       input logic [4:0] f1, input logic [31:0] pc1, input logic [31:0] tg1,
                       input logic d);
    {c0_valid, c0_is_branch, c0_is_jal, c0_taken, c0_pred_taken} = f0;
    {c1_valid, c1_is_branch, c1_is_jal, c1_taken, c1_pred_taken} = f1;
    c0_pc = pc0; c0_target = tg0; c1_pc = pc1; c1_target = tg1;
    drain_en = d;
  endtask

  task automatic enq(input logic v, input logic [31:0] pc, input logic [31:0] tg,
                     input logic br, input logic jal, input logic tk, input logic pd);
    logic r;
    if (v && (br || jal)) begin
      r = jal ? 1'b1 : tk;
      if (r != pd && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
      if (sb.size() < DEPTH) sb.push_back('{pc, tg, br && !jal, jal, r});
      else movf = 1'b1;
    end
  endtask

  // called mid-cycle with inputs settled; checks outputs, advances the model, then crosses the edge
  task automatic step();
    logic ev;
    ev = (sb.size() != 0) && drain_en;
    if (rst) begin
      chk("valid", 32'(btb_upd.valid), 32'(ev));
      chk("ready", 32'(btb_upd.ready), 32'(ev));
      if (ev) begin
        chk("pc", btb_upd.pc, sb[0].pc);
        chk("target", btb_upd.pred_branch_address, sb[0].tg);
        chk("branch_inst", 32'(btb_upd.branch_inst), 32'(sb[0].br));
        chk("jal_inst", 32'(btb_upd.jal_inst), 32'(sb[0].jal));
        chk("resol", 32'(btb_upd.branch_resol), 32'(sb[0].resol));
        void'(sb.pop_front());
      end
      chk("stall", 32'(commit_stall), 32'(sb.size() + (ev ? 1 : 0) > DEPTH - 2));
      chk("mispred", mispred_cnt, mcnt);
      chk("overflow", 32'(overflow_err), 32'(movf));
      enq(c0_valid, c0_pc, c0_target, c0_is_branch, c0_is_jal, c0_taken, c0_pred_taken);
      enq(c1_valid, c1_pc, c1_target, c1_is_branch, c1_is_jal, c1_taken, c1_pred_taken);
    end else begin
      sb.delete();
      mcnt = '0;
      movf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    #4;
    step();
  endtask

  initial begin
    vt[0]  = '{5'b11011, 32'h100, 32'h80,  5'b00000, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   32'd0};
    vt[1]  = '{5'b00000, 32'h0,   32'h0,   5'b00000, 32'h0,   32'h0,   1'b1, 1'b1, 32'h100, 32'd0};
    vt[2]  = '{5'b10101, 32'h200, 32'h400, 5'b11001, 32'h204, 32'h300, 1'b1, 1'b0, 32'h0,   32'd0};
    vt[3]  = '{5'b00000, 32'h0,   32'h0,   5'b00000, 32'h0,   32'h0,   1'b1, 1'b1, 32'h200, 32'd1};
    vt[4]  = '{5'b00000, 32'h0,   32'h0,   5'b00000, 32'h0,   32'h0,   1'b1, 1'b1, 32'h204, 32'd1};
    vt[5]  = '{5'b10000, 32'h2F0, 32'h0,   5'b11011, 32'h300, 32'h340, 1'b1, 1'b0, 32'h0,   32'd1};
    vt[6]  = '{5'b00000, 32'h0,   32'h0,   5'b00000, 32'h0,   32'h0,   1'b1, 1'b1, 32'h300, 32'd1};
    vt[7]  = '{5'b00000, 32'h0,   32'h0,   5'b00000, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   32'd1};
    vt[8]  = '{5'b11100, 32'h500, 32'h700, 5'b00000, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   32'd1};
    vt[9]  = '{5'b00000, 32'h0,   32'h0,   5'b00000, 32'h0,   32'h0,   1'b1, 1'b1, 32'h500, 32'd2};
    vt[10] = '{5'b01011, 32'h900, 32'h0,   5'b11010, 32'h600, 32'h10,  1'b1, 1'b0, 32'h0,   32'd2};
    vt[11] = '{5'b00000, 32'h0,   32'h0,   5'b00000, 32'h0,   32'h0,   1'b1, 1'b1, 32'h600, 32'd3};
    vt[12] = '{5'b00000, 32'h0,   32'h0,   5'b00000, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   32'd3};
    mcnt = '0;
    movf = 1'b0;
    rst = 1'b0;
    drive(5'b0, 32'h0, 32'h0, 5'b0, 32'h0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(btb_upd.valid), 32'h0);
    chk("rst_ready", 32'(btb_upd.ready), 32'h0);
    chk("rst_stall", 32'(commit_stall), 32'h0);
    chk("rst_mispred", mispred_cnt, 32'h0);
    chk("rst_overflow", 32'(overflow_err), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].f0, vt[i].pc0, vt[i].tg0, vt[i].f1, vt[i].pc1, vt[i].tg1, vt[i].drain);
      #4;
      chk($sformatf("vec%0d_valid", i), 32'(btb_upd.valid), 32'(vt[i].ev));
      if (vt[i].ev) chk($sformatf("vec%0d_pc", i), btb_upd.pc, vt[i].epc);
      chk($sformatf("vec%0d_mispred", i), mispred_cnt, vt[i].emis);
      step();
    end

    // fill with the BTB stalled, then push the queue past full
    for (int i = 0; i < 7; i++) begin
      drive({3'b110, i[0], i[0]}, 32'h1000 + 32'(4 * i), 32'h8000 + 32'(i), 5'b0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    drive(5'b0, 32'h0, 32'h0, 5'b0, 32'h0, 32'h0, 1'b0);
    #4;
    chk("full7_stall", 32'(commit_stall), 32'h1);
    step();
    drive(5'b11011, 32'h2000, 32'h20, 5'b10101, 32'h2004, 32'h24, 1'b0);
    tick();
    chk("ovf_set", 32'(overflow_err), 32'h1);
    drive(5'b11010, 32'h3000, 32'h30, 5'b11011, 32'h3004, 32'h34, 1'b1);
    tick();
    drive(5'b0, 32'h0, 32'h0, 5'b0, 32'h0, 32'h0, 1'b1);
    repeat (10) tick();
    chk("ovf_sticky", 32'(overflow_err), 32'h1);

    // mid-operation reset with updates still queued
    for (int i = 0; i < 5; i++) begin
      drive(5'b11010, 32'h4000 + 32'(4 * i), 32'h40, 5'b0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    drive(5'b0, 32'h0, 32'h0, 5'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drain_en = 1'b1;
    #4;
    chk("post_rst_valid", 32'(btb_upd.valid), 32'h0);
    chk("post_rst_mispred", mispred_cnt, 32'h0);
    step();
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/btb_update_queue.md
Name: btb_update_queue

Overview:
- Commit-side producer of the rob_to_btb_bus update stream consumed by the BTB.
- Accepts up to two retiring instructions per cycle from the ROB commit stage and keeps only control-flow instructions (conditional branch or jal).
- Buffers them in program order in a small FIFO and drains at most one update per cycle onto rob_to_btb_bus.
- Also provides commit backpressure, a saturating mispredict counter and a sticky overflow flag.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- PTR_BITS, 3, log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the rising edge of clk)
- c0_valid  in  1  commit slot 0 retiring (older of the two slots)
- c0_pc  in  32  slot 0 PC
- c0_target  in  32  slot 0 resolved target address
- c0_is_branch  in  1  slot 0 is a conditional branch
- c0_is_jal  in  1  slot 0 is a jal
- c0_taken  in  1  slot 0 resolved direction; ignored for jal, which is treated as taken
- c0_pred_taken  in  1  slot 0 direction predicted at fetch
- c1_valid, c1_pc, c1_target, c1_is_branch, c1_is_jal, c1_taken, c1_pred_taken  in  1/32/32/1/1/1/1  slot 1 (younger); same meanings as slot 0
- drain_en  in  1  BTB may accept an update this cycle
- btb_upd  out  rob_to_btb_bus  update to the BTB; fields pc, pred_branch_address, branch_inst, jal_inst, branch_resol, ready, valid
- commit_stall  out  1  fewer than 2 free entries; ROB must not retire this cycle
- mispred_cnt  out  32  saturating count of committed mispredicted control instructions
- overflow_err  out  1  sticky: an enqueue was dropped because the FIFO was full

Behaviour:
- Reset (rst==0 at a clock edge):
  - head, tail and count = 0; FIFO contents are don't-care.
  - btb_upd.valid = btb_upd.ready = 0; mispred_cnt = 0; overflow_err = 0; commit_stall = 0.
  - Asserting reset mid-operation discards all queued updates, with no partial drain.
- Filtering:
  - A slot is enqueued only if cX_valid && (cX_is_branch || cX_is_jal).
  - If both is_branch and is_jal are set, the entry is treated as jal.
- Entry contents:
  - pc = cX_pc
  - pred_branch_address = cX_target
  - branch_inst = cX_is_branch && !cX_is_jal
  - jal_inst = cX_is_jal
  - branch_resol = cX_is_jal ? 1 : cX_taken
- Ordering:
  - If both slots qualify in one cycle, slot 0 is written at tail and slot 1 at tail+1.
  - If only one slot qualifies, it is written at tail. Pointers wrap modulo DEPTH.
- Output:
  - btb_upd is driven combinationally from the head entry.
  - btb_upd.valid = btb_upd.ready = (count != 0) && drain_en.
  - When both are 1, head advances at the clock edge; at most one update leaves per cycle.
  - When count==0 or drain_en==0, valid=ready=0 and the other fields are don't-care.
- Latency:
  - An entry enqueued at edge N is visible on btb_upd from cycle N+1 if it is at head and drain_en is high.
  - There is no same-cycle bypass from the commit inputs to btb_upd.
- Count arithmetic:
  - count_next = count + enq_n - deq.
  - enq_n is in 0..2 and deq is in 0..1, so simultaneous enqueue and dequeue are legal.
  - count width is PTR_BITS+1.
- Backpressure:
  - commit_stall = (count > DEPTH-2), decoded from the count register only.
- Overflow:
  - If an enqueue would exceed DEPTH after counting the same-cycle dequeue, excess entries are dropped, youngest first, and overflow_err is set.
  - overflow_err clears only on reset. Retiring while commit_stall is high is a ROB protocol violation.
- Mispredict counter:
  - Increments by the number of qualifying slots in the cycle (0, 1 or 2) where branch_resol != cX_pred_taken.
  - Saturates at 0xFFFFFFFF.
  - Counted at enqueue time, including entries dropped on overflow.

Test Plan:
- Reset, then drain_en=1; c0 branch pc=0x100 target=0x80 taken=1 -> next cycle btb_upd.valid=1, pc=0x100, pred_branch_address=0x80, branch_inst=1, branch_resol=1; the cycle after, valid=0.
- Same cycle: c0 jal pc=0x200, c1 branch pc=0x204 taken=0 pred_taken=1 -> updates 0x200 (jal_inst=1, resol=1) then 0x204 (resol=0) on consecutive cycles; mispred_cnt=1.
- c0 add (both type bits 0, valid=1), c1 branch pc=0x300 -> exactly one update, pc=0x300.
- drain_en=0 with 7 branches enqueued -> commit_stall=1 once count=7; count=6 gives commit_stall=0; raising drain_en drains all 7 in order, one per cycle.
- drain_en=0, count=7, force two qualifying commits -> slot 0 stored, slot 1 dropped, overflow_err=1 and stays 1 until reset.
- With 5 queued updates, drive rst=0 for one cycle -> btb_upd.valid=0 and count=0 the next cycle; mispred_cnt=0 and no stale update ever appears.
